// File: rtl/spi_stream_tx.sv
// rtl/spi_stream_tx.sv - Single-buffered SPI-style serializer for LED strip data
//
// Accepts words through a one-entry holding buffer and shifts them out on
// spi_output_data with a generated serial clock (spi_output_clock, idle low).
// Data changes while the serial clock is low and is sampled by the strip on
// the rising edge. A buffered word is picked up on the same edge that ends
// the previous word, so a continuous stream has no gap between words.
//
// Parameters:
//   DATA_WIDTH  bits per word (2..32)
//   HALF_PERIOD spi_clk cycles per serial clock phase (1..255)
//   LSB_FIRST   0 = MSB first, 1 = LSB first
//
// Ports:
//   spi_clk          in   single rising-edge clock
//   spi_reset_n      in   asynchronous active-low reset
//   spi_start        in   word-valid request, accepted when spi_ready=1
//   spi_data_in      in   word to transmit, sampled only on accept
//   spi_ready        out  holding buffer empty
//   spi_busy         out  shifter active or holding buffer full
//   spi_done         out  one-cycle pulse per completed word
//   spi_output_data  out  serial data
//   spi_output_clock out  serial clock, idles low

module spi_stream_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int HALF_PERIOD = 6,
  parameter int LSB_FIRST   = 0
) (
  input  logic                  spi_clk,
  input  logic                  spi_reset_n,
  input  logic                  spi_start,
  input  logic [DATA_WIDTH-1:0] spi_data_in,
  output logic                  spi_ready,
  output logic                  spi_busy,
  output logic                  spi_done,
  output logic                  spi_output_data,
  output logic                  spi_output_clock
);

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [PW-1:0] PH_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [PW-1:0]         phase, phase_n;
  logic [BW-1:0]         bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] shift_reg, shift_n;
  logic [DATA_WIDTH-1:0] buf_data, buf_data_n;
  logic                  buf_full, buf_full_n;
  logic                  sdo_n, sclk_n, done_n, busy_n, ready_n;
  logic                  do_load;

  // Bit that goes on the wire first for a given shifter content.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_WIDTH-1];
  endfunction

  // Shifter content after the current wire bit has been consumed.
  function automatic logic [DATA_WIDTH-1:0] shifted(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  always_ff @(posedge spi_clk or negedge spi_reset_n) begin
    if (!spi_reset_n) begin
      state            <= ST_IDLE;
      phase            <= '0;
      bit_cnt          <= '0;
      shift_reg        <= '0;
      buf_data         <= '0;
      buf_full         <= 1'b0;
      spi_output_data  <= 1'b0;
      spi_output_clock <= 1'b0;
      spi_done         <= 1'b0;
      spi_busy         <= 1'b0;
      spi_ready        <= 1'b1;
    end else begin
      state            <= state_n;
      phase            <= phase_n;
      bit_cnt          <= bit_cnt_n;
      shift_reg        <= shift_n;
      buf_data         <= buf_data_n;
      buf_full         <= buf_full_n;
      spi_output_data  <= sdo_n;
      spi_output_clock <= sclk_n;
      spi_done         <= done_n;
      spi_busy         <= busy_n;
      spi_ready        <= ready_n;
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_reg;
    buf_data_n = buf_data;
    buf_full_n = buf_full;
    sdo_n      = spi_output_data;
    sclk_n     = spi_output_clock;
    done_n     = 1'b0;
    do_load    = 1'b0;

    // spi_ready mirrors the buffer-empty flag, so accept and load can never
    // coincide: accept needs the buffer empty, load needs it full.
    if (spi_start && spi_ready) begin
      buf_full_n = 1'b1;
      buf_data_n = spi_data_in;
    end

    case (state)
      ST_IDLE: begin
        sclk_n = 1'b0;
        if (buf_full) do_load = 1'b1;
      end

      ST_SETUP: begin
        if (phase == PH_LAST) begin
          sclk_n  = 1'b1;
          phase_n = '0;
          state_n = ST_HIGH;
        end else begin
          phase_n = phase + 1'b1;
        end
      end

      ST_HIGH: begin
        if (phase == PH_LAST) begin
          sclk_n  = 1'b0;
          phase_n = '0;
          if (bit_cnt != BIT_LAST) begin
            shift_n   = shifted(shift_reg);
            sdo_n     = first_bit(shifted(shift_reg));
            bit_cnt_n = bit_cnt + 1'b1;
            state_n   = ST_SETUP;
          end else begin
            done_n = 1'b1;
            if (buf_full) begin
              do_load = 1'b1;
            end else begin
              sdo_n     = 1'b0;
              bit_cnt_n = '0;
              state_n   = ST_IDLE;
            end
          end
        end else begin
          phase_n = phase + 1'b1;
        end
      end

      default: begin
        // Recovery from a corrupted state register: behave as if reset.
        state_n    = ST_IDLE;
        phase_n    = '0;
        bit_cnt_n  = '0;
        shift_n    = '0;
        buf_data_n = '0;
        buf_full_n = 1'b0;
        sdo_n      = 1'b0;
        sclk_n     = 1'b0;
        done_n     = 1'b0;
      end
    endcase

    // Load from the holding buffer: used both from idle and at the end of a
    // word so that back-to-back words run without a gap.
    if (do_load) begin
      shift_n    = buf_data;
      sdo_n      = first_bit(buf_data);
      buf_full_n = 1'b0;
      bit_cnt_n  = '0;
      phase_n    = '0;
      state_n    = ST_SETUP;
    end

    busy_n  = (state_n != ST_IDLE) || buf_full_n;
    ready_n = !buf_full_n;
  end

endmodule
